// File: rtl/cdu_read_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cdu_read_counter                                               |
// | Brief   : CDU read-counter stage. Accumulates step edges into a 16-bit   |
// |           angle and drains a signed pending count to the AGC over a      |
// |           plus/minus request-acknowledge handshake.                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cdu_read_counter #(
  parameter int W_F1   = 1,
  parameter int W_F2   = 4,
  parameter int W_C1   = 64,
  parameter int PEND_W = 9
) (
  input  logic              CLOCKH,
  input  logic              rst,
  input  logic              CCDUZ,
  input  logic              UPLVL,
  input  logic              DNLVL,
  input  logic              TPF1,
  input  logic              TPF2,
  input  logic              TPC1,
  input  logic              AGC_ACK,
  output logic              PLUS_REQ,
  output logic              MINUS_REQ,
  output logic [15:0]       READ_CTR,
  output logic [PEND_W-1:0] PEND,
  output logic              OVF
);

  // Internal arithmetic width: wide enough for the 16-bit angle delta and for
  // PEND + delta - ack without overflowing before the clamp is applied.
  localparam int SW = ((PEND_W > 16) ? PEND_W : 16) + 2;

  localparam logic signed [SW-1:0] c_w_f1 = SW'(W_F1);
  localparam logic signed [SW-1:0] c_w_f2 = SW'(W_F2);
  localparam logic signed [SW-1:0] c_w_c1 = SW'(W_C1);
  localparam logic signed [SW-1:0] c_pmax = SW'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [SW-1:0] c_nmax = -c_pmax;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ_P = 2'd1,
    S_REQ_M = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          hist_q, hist_d;
  logic [15:0]         read_q, read_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;

  logic [2:0]          w_edges;
  logic                w_up;
  logic                w_dn;
  logic signed [SW-1:0] w_mag;
  logic signed [SW-1:0] w_delta;
  logic signed [SW-1:0] w_ack_term;
  logic signed [SW-1:0] w_pend_ext;
  logic signed [SW-1:0] w_sum;
  logic                w_ack_acc;
  logic                w_pend_pos;
  logic                w_pend_neg;

  // Step decode and delta
  always_comb begin
    hist_d  = {TPC1, TPF2, TPF1};
    w_edges = hist_d & ~hist_q;
    w_up    = UPLVL & ~DNLVL;
    w_dn    = DNLVL & ~UPLVL;
    w_mag   = (w_edges[0] ? c_w_f1 : '0)
            + (w_edges[1] ? c_w_f2 : '0)
            + (w_edges[2] ? c_w_c1 : '0);
    w_delta = '0;
    if (w_up) begin
      w_delta = w_mag;
    end else if (w_dn) begin
      w_delta = -w_mag;
    end
  end

  // Acknowledge accounting: only an ack seen while a request is live counts.
  always_comb begin
    w_ack_acc  = AGC_ACK & ((state_q == S_REQ_P) | (state_q == S_REQ_M));
    w_ack_term = '0;
    if (w_ack_acc) begin
      w_ack_term = (state_q == S_REQ_P) ? SW'(1) : -SW'(1);
    end
  end

  // Accumulators with saturation on the pending count
  always_comb begin
    w_pend_ext = {{(SW - PEND_W){pend_q[PEND_W-1]}}, pend_q};
    w_sum      = w_pend_ext + w_delta - w_ack_term;
    read_d     = read_q + w_delta[15:0];
    pend_d     = w_sum[PEND_W-1:0];
    ovf_d      = ovf_q;
    if (w_sum > c_pmax) begin
      pend_d = c_pmax[PEND_W-1:0];
      ovf_d  = 1'b1;
    end else if (w_sum < c_nmax) begin
      pend_d = c_nmax[PEND_W-1:0];
      ovf_d  = 1'b1;
    end
    if (CCDUZ) begin
      read_d = '0;
      pend_d = '0;
      ovf_d  = 1'b0;
    end
  end

  // Request FSM next state
  always_comb begin
    w_pend_neg = pend_q[PEND_W-1];
    w_pend_pos = ~pend_q[PEND_W-1] & (|pend_q);
    state_d    = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_pend_pos) begin
          state_d = S_REQ_P;
        end else if (w_pend_neg) begin
          state_d = S_REQ_M;
        end
      end
      S_REQ_P, S_REQ_M: begin
        if (AGC_ACK) begin
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (CCDUZ) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLOCKH) begin
    if (rst) begin
      state_q <= S_IDLE;
      hist_q  <= '0;
      read_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      read_q  <= read_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign PLUS_REQ  = (state_q == S_REQ_P);
  assign MINUS_REQ = (state_q == S_REQ_M);
  assign READ_CTR  = read_q;
  assign PEND      = pend_q;
  assign OVF       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cdu_read_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cdu_read_counter                                            |
// | Brief   : Directed bench for cdu_read_counter with a request scoreboard.  |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_cdu_read_counter;

  logic       CLOCKH = 1'b0;
  logic       rst = 1'b1;
  logic       CCDUZ = 1'b0;
  logic       UPLVL = 1'b0;
  logic       DNLVL = 1'b0;
  logic       TPF1 = 1'b0;
  logic       TPF2 = 1'b0;
  logic       TPC1 = 1'b0;
  logic       AGC_ACK = 1'b0;
  logic       PLUS_REQ;
  logic       MINUS_REQ;
  logic [15:0] READ_CTR;
  logic [8:0] PEND;
  logic       OVF;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];   // 1 = plus request expected, 0 = minus

  cdu_read_counter #(
    .W_F1(1), .W_F2(4), .W_C1(64), .PEND_W(9)
  ) dut (
    .CLOCKH   (CLOCKH),
    .rst      (rst),
    .CCDUZ    (CCDUZ),
    .UPLVL    (UPLVL),
    .DNLVL    (DNLVL),
    .TPF1     (TPF1),
    .TPF2     (TPF2),
    .TPC1     (TPC1),
    .AGC_ACK  (AGC_ACK),
    .PLUS_REQ (PLUS_REQ),
    .MINUS_REQ(MINUS_REQ),
    .READ_CTR (READ_CTR),
    .PEND     (PEND),
    .OVF      (OVF)
  );

  always #5 CLOCKH = ~CLOCKH;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLOCKH);
    #1;
  endtask

  task automatic step(input bit f1, input bit f2, input bit c1);
    TPF1 = f1; TPF2 = f2; TPC1 = c1;
    tick();
    TPF1 = 1'b0; TPF2 = 1'b0; TPC1 = 1'b0;
    tick();
  endtask

  task automatic zero_cmd();
    CCDUZ = 1'b1;
    tick();
    CCDUZ = 1'b0;
  endtask

  task automatic push_n(input bit dir, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(dir);
  endtask

  // Monitor: every accepted request is popped against the scoreboard.
  always @(negedge CLOCKH) begin
    if (PLUS_REQ && MINUS_REQ) begin
      total++;
      bad++;
      $display("FAIL req_excl: got plus=1 minus=1 expected at most one");
    end
    if (!rst && !CCDUZ && AGC_ACK && (PLUS_REQ || MINUS_REQ)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL req_unexp: got plus=%0d minus=%0d expected no request",
                 PLUS_REQ, MINUS_REQ);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (PLUS_REQ != e) begin
          bad++;
          $display("FAIL req_dir: got plus=%0d expected plus=%0d", PLUS_REQ, e);
        end
      end
    end
  end

  initial begin
    int hits[$];

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_ctr", int'(READ_CTR), 0);
    chk("rst_pend", int'($signed(PEND)), 0);
    chk("rst_ovf", int'(OVF), 0);
    chk("rst_req", int'({PLUS_REQ, MINUS_REQ}), 0);

    // 1: three fine-1 up steps, then drain with ack held high
    UPLVL = 1'b1;
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("t1_ctr", int'(READ_CTR), 3);
    chk("t1_pend", int'($signed(PEND)), 3);
    chk("t1_req", int'(PLUS_REQ), 1);
    push_n(1'b1, 3);
    AGC_ACK = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (PLUS_REQ) hits.push_back(i);
      tick();
    end
    AGC_ACK = 1'b0;
    chk("t1_npulse", hits.size(), 3);
    if (hits.size() == 3) begin
      chk("t1_gap0", hits[1] - hits[0], 3);
      chk("t1_gap1", hits[2] - hits[1], 3);
    end
    chk("t1_pend_end", int'($signed(PEND)), 0);

    // 2: one coarse down step from zero, drain 64 minus requests
    zero_cmd();
    chk("t2_zero", int'(READ_CTR), 0);
    UPLVL = 1'b0; DNLVL = 1'b1;
    push_n(1'b0, 64);
    AGC_ACK = 1'b1;
    step(0, 0, 1);
    chk("t2_ctr", int'(READ_CTR), 'hFFC0);
    chk("t2_pend", int'($signed(PEND)), -64);
    repeat (64 * 3 + 6) tick();
    AGC_ACK = 1'b0;
    chk("t2_pend_end", int'($signed(PEND)), 0);
    chk("t2_ovf", int'(OVF), 0);
    chk("t2_q", exp_q.size(), 0);

    // 3: all three edges together; up gives +69, both levels gives nothing
    DNLVL = 1'b0; UPLVL = 1'b1;
    step(1, 1, 1);
    chk("t3_ctr", int'(READ_CTR), 5);
    chk("t3_pend", int'($signed(PEND)), 69);
    DNLVL = 1'b1;
    step(1, 1, 1);
    chk("t3_ctr_both", int'(READ_CTR), 5);
    chk("t3_pend_both", int'($signed(PEND)), 69);
    DNLVL = 1'b0;
    push_n(1'b1, 69);
    AGC_ACK = 1'b1;
    repeat (69 * 3 + 6) tick();
    AGC_ACK = 1'b0;
    chk("t3_pend_end", int'($signed(PEND)), 0);
    chk("t3_q", exp_q.size(), 0);

    // 4: saturation and zero command
    zero_cmd();
    step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    chk("t4_pend192", int'($signed(PEND)), 192);
    chk("t4_ovf0", int'(OVF), 0);
    step(0, 0, 1); step(0, 0, 1);
    chk("t4_pend_sat", int'($signed(PEND)), 255);
    chk("t4_ovf1", int'(OVF), 1);
    chk("t4_ctr", int'(READ_CTR), 320);
    zero_cmd();
    chk("t4_z_ctr", int'(READ_CTR), 0);
    chk("t4_z_pend", int'($signed(PEND)), 0);
    chk("t4_z_ovf", int'(OVF), 0);
    chk("t4_z_req", int'({PLUS_REQ, MINUS_REQ}), 0);

    // 5: down step lands in the same cycle as a plus acknowledge
    step(1, 0, 0);
    chk("t5_pend1", int'($signed(PEND)), 1);
    chk("t5_plus", int'(PLUS_REQ), 1);
    push_n(1'b1, 1);
    AGC_ACK = 1'b1; UPLVL = 1'b0; DNLVL = 1'b1; TPF2 = 1'b1;
    tick();
    AGC_ACK = 1'b0; TPF2 = 1'b0;
    chk("t5_pend", int'($signed(PEND)), -4);
    chk("t5_ctr", int'(READ_CTR), 'hFFFD);
    chk("t5_gap", int'({PLUS_REQ, MINUS_REQ}), 0);
    tick();
    chk("t5_idle", int'({PLUS_REQ, MINUS_REQ}), 0);
    tick();
    chk("t5_minus", int'({PLUS_REQ, MINUS_REQ}), 1);
    push_n(1'b0, 4);
    AGC_ACK = 1'b1;
    repeat (4 * 3 + 6) tick();
    AGC_ACK = 1'b0;
    chk("t5_pend_end", int'($signed(PEND)), 0);
    chk("t5_q", exp_q.size(), 0);

    // 6: reset in the middle of an outstanding request
    zero_cmd();
    DNLVL = 1'b0; UPLVL = 1'b1;
    step(0, 1, 0); step(0, 1, 0); step(1, 0, 0); step(1, 0, 0);
    chk("t6_pend", int'($signed(PEND)), 10);
    chk("t6_plus", int'(PLUS_REQ), 1);
    rst = 1'b1; AGC_ACK = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ctr", int'(READ_CTR), 0);
    chk("t6_pend0", int'($signed(PEND)), 0);
    chk("t6_ovf", int'(OVF), 0);
    chk("t6_req", int'({PLUS_REQ, MINUS_REQ}), 0);
    repeat (3) tick();
    AGC_ACK = 1'b0;
    chk("t6_req_after", int'({PLUS_REQ, MINUS_REQ}), 0);
    chk("t6_pend_after", int'($signed(PEND)), 0);

    chk("final_q", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
